mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one Wishbone-style memory port between instruction fetch (IF stage) and data access (MEM stage) of the 5-stage core.
- Sequences the port with a small FSM and captures read data.
- Generates stall_pipl for the control unit's pipeline controller until every pending pipeline request has been served.
- Detects hung bus cycles with a watchdog and reports them.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; must be 32.
- TIMEOUT_CYCLES, 255, cycles in a bus wait before the watchdog fires; range 1..255.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, level, held while stalled
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, held until the next fetch completes
- d_req  in  1  data request, level, held while stalled
- d_we  in  1  data write enable
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_sel  in  4  byte lane select
- d_rdata  out  DATA_W  load data, held until the next data completion
- bus_cyc  out  1  bus cycle active
- bus_stb  out  1  bus strobe (equal to bus_cyc)
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_sel  out  4  bus byte select; 4'hF for fetch
- bus_rdata  in  DATA_W  bus read data
- bus_ack  in  1  bus transfer complete
- stall_pipl  out  1  freeze pipeline
- bus_err  out  1  one-cycle pulse on watchdog timeout

Behaviour:
- States: IDLE, D_WAIT, I_WAIT.
- Reset: state=IDLE; all bus_* outputs 0; if_rdata=0; d_rdata=0; if_done=0; d_done=0; wdog=0; bus_err=0. Reset wins over any in-flight transfer. bus_cyc drops at the reset edge and any late bus_ack is ignored.
- Served flags:
  - d_pend = d_req & ~d_done; i_pend = if_req & ~if_done.
  - A flag is set on completion of its transfer (ack or timeout).
  - Both flags clear on any cycle where stall_pipl=0, i.e. the pipeline advances.
- Start of a transfer (from IDLE, or back-to-back from a WAIT state):
  - Data has priority over fetch (older instruction).
  - d_pend → D_WAIT. Register bus_addr=d_addr, bus_we=d_we, bus_wdata=d_wdata, bus_sel=d_sel; bus_cyc=bus_stb=1.
  - Else i_pend → I_WAIT. Register bus_addr=if_addr, bus_we=0, bus_sel=4'hF.
  - Else stay in IDLE.
- Bus signals are registered and stable for the whole wait. First bus_cyc appears 1 cycle after the request is seen.
- In a WAIT state:
  - wdog increments every cycle.
  - On bus_ack: capture bus_rdata into d_rdata (reads only; writes leave d_rdata unchanged) or into if_rdata. Set the matching done flag. Clear wdog.
  - If the other request is still pending, start it next cycle with bus_cyc held high (back-to-back). Otherwise go to IDLE with bus_cyc=0.
  - Minimum transfer latency: 2 cycles from request to data with a zero-wait-state slave (ack in the first bus_cyc cycle).
- Watchdog: when wdog reaches TIMEOUT_CYCLES with no ack:
  - Pulse bus_err for 1 cycle.
  - Treat as completion with rdata=0 (load/fetch result 32'h0).
  - Drop bus_cyc and follow the same next-state rule as an ack.
  - An ack on the same cycle as the timeout counts as an ack, with no bus_err.
- stall_pipl (combinational):
  - stall_pipl = (d_req & ~d_done & ~d_fin) | (if_req & ~if_done & ~i_fin).
  - d_fin / i_fin = completion occurring this cycle for that requester.
  - Result: the pipeline advances in the same cycle the last needed ack arrives.
- Request withdrawn while in WAIT (flush): the bus transfer still completes. Its data is captured but its done flag is not set if its req is low.
- bus_ack while IDLE is ignored.

Decomposition:
- Shared package: arb_state_t enum (IDLE, D_WAIT, I_WAIT); the localparam FETCH_SEL=4'hF; the timeout-data constant 32'h0.
- Natural sub-module: arb_watchdog, a counter with clear/enable inputs and a timeout output.
- The FSM, request latches and read-data capture stay in the top module.

Test Plan:
- Fetch only, zero-wait slave, if_addr=0x100, bus_rdata=0x00000013:
  - bus_cyc rises at cycle 1, ack at cycle 1.
  - if_rdata=0x13 and stall_pipl low in cycle 1; stall_pipl high in cycle 0.
- d_req (load, 0x2000) and if_req (0x104) together, slave 1 wait state:
  - Data served first, then fetch back-to-back with bus_cyc never dropping.
  - stall_pipl falls on the fetch ack.
  - d_rdata and if_rdata hold their values.
- Store with d_sel=4'b0011, d_wdata=0xAABBCCDD:
  - bus_we=1, bus_sel=0011, bus_wdata matches.
  - d_rdata unchanged.
- Slave never acks, TIMEOUT_CYCLES=4:
  - bus_err pulses exactly once, 4 cycles into the wait.
  - d_rdata=0, bus_cyc=0, stall_pipl released.
- reset asserted mid D_WAIT, then a late bus_ack:
  - Next edge: all outputs 0, state IDLE.
  - The late ack changes nothing.
- if_req withdrawn during I_WAIT (flush):
  - Transfer completes; if_done stays 0.
  - A new if_req at 0x200 is served afresh.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter shared types and constants.
// Port-owner states and fixed bus values.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2
    } arb_state_t;

    localparam logic [3:0]  FETCH_SEL    = 4'hF;
    localparam logic [31:0] TIMEOUT_DATA = 32'h0;
    localparam int          WDOG_W       = 8;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Bus-wait watchdog for mem_port_arbiter.
// Counts wait cycles; flags the last allowed one.
module arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam logic [WDOG_W-1:0] LP_LAST =
        WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] r_cnt;

    // wait-cycle counter, restarted at every transfer boundary
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // fires in the TIMEOUT_CYCLES-th cycle of a wait
    assign o_timeout = i_en & (r_cnt == LP_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared fetch/data Wishbone port arbiter.
// Data first, back-to-back transfers, watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    input  logic [3:0]        i_d_sel,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_bus_cyc,
    output logic              o_bus_stb,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    output logic [3:0]        o_bus_sel,
    input  logic [DATA_W-1:0] i_bus_rdata,
    input  logic              i_bus_ack,
    output logic              o_stall_pipl,
    output logic              o_bus_err
);

    arb_state_t        r_state;
    arb_state_t        w_state_nx;
    logic              w_load;

    logic              r_d_done;
    logic              r_if_done;

    logic              r_bus_cyc;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [3:0]        r_bus_sel;
    logic              r_bus_err;

    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_wait;
    logic              w_timeout;
    logic              w_ack;
    logic              w_to;
    logic              w_xfer_end;
    logic              w_d_fin;
    logic              w_i_fin;
    logic              w_d_want;
    logic              w_i_want;
    logic              w_stall;
    logic              w_d_cap;
    logic [DATA_W-1:0] w_cap_data;

    assign w_wait = (r_state != IDLE);

    // an ack on the timeout cycle wins over the timeout
    assign w_ack      = w_wait & i_bus_ack;
    assign w_to       = w_timeout & ~i_bus_ack;
    assign w_xfer_end = w_ack | w_to;

    assign w_d_fin = (r_state == D_WAIT) & w_xfer_end;
    assign w_i_fin = (r_state == I_WAIT) & w_xfer_end;

    // requests still needing a bus transfer after this cycle
    assign w_d_want = i_d_req  & ~r_d_done  & ~w_d_fin;
    assign w_i_want = i_if_req & ~r_if_done & ~w_i_fin;

    assign w_stall  = w_d_want | w_i_want;

    assign w_cap_data = w_ack ? i_bus_rdata : TIMEOUT_DATA;
    assign w_d_cap    = w_d_fin & ~r_bus_we;

    arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (~w_wait | w_xfer_end),
        .i_en      (w_wait),
        .o_timeout (w_timeout)
    );

    // state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // next owner: data before fetch, at idle or at a transfer end
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_d_want) begin
                    w_state_nx = D_WAIT;
                    w_load     = 1'b1;
                end else if (w_i_want) begin
                    w_state_nx = I_WAIT;
                    w_load     = 1'b1;
                end
            end
            D_WAIT, I_WAIT: begin
                if (w_xfer_end) begin
                    if (w_d_want) begin
                        w_state_nx = D_WAIT;
                        w_load     = 1'b1;
                    end else if (w_i_want) begin
                        w_state_nx = I_WAIT;
                        w_load     = 1'b1;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // registered bus request, stable for the whole wait
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bus_cyc   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_sel   <= '0;
        end else if (w_load) begin
            r_bus_cyc <= 1'b1;
            if (w_state_nx == D_WAIT) begin
                r_bus_we    <= i_d_we;
                r_bus_addr  <= i_d_addr;
                r_bus_wdata <= i_d_wdata;
                r_bus_sel   <= i_d_sel;
            end else begin
                r_bus_we    <= 1'b0;
                r_bus_addr  <= i_if_addr;
                r_bus_sel   <= FETCH_SEL;
            end
        end else if (w_xfer_end) begin
            r_bus_cyc <= 1'b0;
        end
    end

    // served flags, dropped whenever the pipeline advances
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_d_done  <= 1'b0;
            r_if_done <= 1'b0;
        end else if (!w_stall) begin
            r_d_done  <= 1'b0;
            r_if_done <= 1'b0;
        end else begin
            if (w_d_fin && i_d_req) begin
                r_d_done <= 1'b1;
            end
            if (w_i_fin && i_if_req) begin
                r_if_done <= 1'b1;
            end
        end
    end

    // read-data capture; stores leave load data alone
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_i_fin) begin
                r_if_rdata <= w_cap_data;
            end
            if (w_d_cap) begin
                r_d_rdata <= w_cap_data;
            end
        end
    end

    // one-cycle error pulse after a watchdog expiry
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_to;
        end
    end

    // completion data is forwarded so the pipeline can advance on the ack
    assign o_if_rdata = w_i_fin ? w_cap_data : r_if_rdata;
    assign o_d_rdata  = w_d_cap ? w_cap_data : r_d_rdata;

    assign o_bus_cyc    = r_bus_cyc;
    assign o_bus_stb    = r_bus_cyc;
    assign o_bus_we     = r_bus_we;
    assign o_bus_addr   = r_bus_addr;
    assign o_bus_wdata  = r_bus_wdata;
    assign o_bus_sel    = r_bus_sel;
    assign o_stall_pipl = w_stall;
    assign o_bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter.
// Directed scenarios plus randomized traffic vs. a reference model.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    logic [31:0] d_rdata;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;
    logic        stall;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_if_req     (if_req),
        .i_if_addr    (if_addr),
        .o_if_rdata   (if_rdata),
        .i_d_req      (d_req),
        .i_d_we       (d_we),
        .i_d_addr     (d_addr),
        .i_d_wdata    (d_wdata),
        .i_d_sel      (d_sel),
        .o_d_rdata    (d_rdata),
        .o_bus_cyc    (bus_cyc),
        .o_bus_stb    (bus_stb),
        .o_bus_we     (bus_we),
        .o_bus_addr   (bus_addr),
        .o_bus_wdata  (bus_wdata),
        .o_bus_sel    (bus_sel),
        .i_bus_rdata  (bus_rdata),
        .i_bus_ack    (bus_ack),
        .o_stall_pipl (stall),
        .o_bus_err    (bus_err)
    );

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- bus slave ----------------
    int          s_mode  = 0;
    logic [31:0] s_data  = 32'h0;
    int          s_wait  = 0;
    bit          s_rand  = 1'b0;
    bit          s_force = 1'b0;
    int          s_cnt   = 0;
    int          s_cur   = 0;
    bit          s_acked = 1'b0;
    bit          s_prev  = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!bus_cyc || !s_prev || s_acked || bus_err) s_cnt = 0;
        else s_cnt++;
        s_prev = bus_cyc;
        if (!s_rand) s_cur = s_wait;
        else if (s_cnt == 0) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) s_cur = r % 3;
            else if (r < 9) s_cur = 3;
            else s_cur = 255;
        end
        if (bus_cyc) bus_ack = (s_cur != 255) && (s_cnt == s_cur);
        else bus_ack = s_force || (s_rand && $urandom_range(0, 3) == 0);
        s_acked = bus_ack;
        case (s_mode)
            0:       bus_rdata = s_data;
            1:       bus_rdata = bus_addr ^ 32'h5A5A0000;
            default: bus_rdata = $urandom;
        endcase
    end

    // ---------------- reference model ----------------
    int          m_own = 0;
    int          m_age = 0;
    bit          m_ok  = 1'b0;
    logic        m_we;
    logic [31:0] m_addr, m_wd, m_ir, m_dr;
    logic [3:0]  m_sel;
    bit          m_err, m_dd, m_id;

    always @(negedge clk) begin
        if (reset) begin
            m_ok = 1'b1; m_own = 0; m_age = 0; m_we = 1'b0;
            m_addr = 32'h0; m_wd = 32'h0; m_sel = 4'h0;
            m_ir = 32'h0; m_dr = 32'h0;
            m_err = 1'b0; m_dd = 1'b0; m_id = 1'b0;
        end else if (m_ok) begin
            bit ack, fin, tmo, dfin, ifin, e_stall, wd, wi;
            logic [31:0] cap, eir, edr;
            ack  = (m_own != 0) && bus_ack;
            fin  = (m_own != 0) && (bus_ack || (m_age + 1 == TO));
            tmo  = fin && !bus_ack;
            cap  = ack ? bus_rdata : 32'h0;
            dfin = fin && (m_own == 1);
            ifin = fin && (m_own == 2);
            eir  = ifin ? cap : m_ir;
            edr  = (dfin && !m_we) ? cap : m_dr;
            wd   = d_req && !m_dd && !dfin;
            wi   = if_req && !m_id && !ifin;
            e_stall = wd || wi;
            chk1("m_cyc", bus_cyc, m_own != 0);
            chk1("m_stb", bus_stb, m_own != 0);
            if (m_own != 0) begin
                chk32("m_addr", bus_addr, m_addr);
                chk1("m_we", bus_we, m_we);
                chk32("m_sel", {28'h0, bus_sel}, {28'h0, m_sel});
                if (m_own == 1 && m_we) chk32("m_wdata", bus_wdata, m_wd);
            end
            chk1("m_err", bus_err, m_err);
            chk1("m_stall", stall, e_stall);
            chk32("m_if_rdata", if_rdata, eir);
            chk32("m_d_rdata", d_rdata, edr);
            m_err = tmo;
            m_ir  = eir;
            m_dr  = edr;
            if (!e_stall) begin
                m_dd = 1'b0;
                m_id = 1'b0;
            end else begin
                if (dfin && d_req) m_dd = 1'b1;
                if (ifin && if_req) m_id = 1'b1;
            end
            if (m_own == 0 || fin) begin
                m_age = 0;
                if (wd) begin
                    m_own = 1; m_addr = d_addr; m_we = d_we;
                    m_wd = d_wdata; m_sel = d_sel;
                end else if (wi) begin
                    m_own = 2; m_addr = if_addr; m_we = 1'b0; m_sel = 4'hF;
                end else begin
                    m_own = 0;
                end
            end else begin
                m_age++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        int  errs;
        bit  last_stall;
        reset = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0;
        d_wdata = 32'h0; d_sel = 4'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mid();
        chk1("rst_cyc", bus_cyc, 1'b0);
        chk1("rst_stb", bus_stb, 1'b0);
        chk1("rst_we", bus_we, 1'b0);
        chk32("rst_addr", bus_addr, 32'h0);
        chk32("rst_wdata", bus_wdata, 32'h0);
        chk32("rst_sel", {28'h0, bus_sel}, 32'h0);
        chk1("rst_err", bus_err, 1'b0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);

        // fetch only, zero-wait slave
        s_mode = 0; s_data = 32'h13; s_wait = 0;
        step(); if_req = 1'b1; if_addr = 32'h100;
        mid();
        chk1("f_stall_c0", stall, 1'b1);
        chk1("f_cyc_c0", bus_cyc, 1'b0);
        step(); mid();
        chk1("f_cyc_c1", bus_cyc, 1'b1);
        chk32("f_addr_c1", bus_addr, 32'h100);
        chk32("f_sel_c1", {28'h0, bus_sel}, 32'hF);
        chk32("f_rdata_c1", if_rdata, 32'h13);
        chk1("f_stall_c1", stall, 1'b0);
        step(); if_req = 1'b0;
        mid();
        chk1("f_cyc_c2", bus_cyc, 1'b0);
        chk32("f_rdata_c2", if_rdata, 32'h13);

        // load + fetch together, one wait state
        s_mode = 1; s_wait = 1;
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_sel = 4'hF;
        if_req = 1'b1; if_addr = 32'h104;
        mid(); chk1("b_stall_c0", stall, 1'b1);
        step(); mid();
        chk1("b_cyc_c1", bus_cyc, 1'b1);
        chk32("b_addr_c1", bus_addr, 32'h2000);
        step(); mid();
        chk1("b_cyc_c2", bus_cyc, 1'b1);
        chk32("b_drd_c2", d_rdata, 32'h5A5A2000);
        chk1("b_stall_c2", stall, 1'b1);
        step(); mid();
        chk1("b_cyc_c3", bus_cyc, 1'b1);
        chk32("b_addr_c3", bus_addr, 32'h104);
        chk1("b_stall_c3", stall, 1'b1);
        step(); mid();
        chk1("b_cyc_c4", bus_cyc, 1'b1);
        chk32("b_ird_c4", if_rdata, 32'h5A5A0104);
        chk1("b_stall_c4", stall, 1'b0);
        step(); d_req = 1'b0; if_req = 1'b0;
        mid();
        chk1("b_cyc_c5", bus_cyc, 1'b0);
        chk32("b_ird_c5", if_rdata, 32'h5A5A0104);
        chk32("b_drd_c5", d_rdata, 32'h5A5A2000);

        // store with partial byte select
        s_wait = 0;
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000;
        d_wdata = 32'hAABBCCDD; d_sel = 4'b0011;
        mid();
        step(); mid();
        chk1("s_we", bus_we, 1'b1);
        chk32("s_sel", {28'h0, bus_sel}, 32'h3);
        chk32("s_wdata", bus_wdata, 32'hAABBCCDD);
        chk32("s_drd", d_rdata, 32'h5A5A2000);
        chk1("s_stall", stall, 1'b0);
        step(); d_req = 1'b0; d_we = 1'b0;
        mid(); chk32("s_drd_after", d_rdata, 32'h5A5A2000);

        // slave never acks: watchdog
        s_wait = 255;
        step(); d_req = 1'b1; d_addr = 32'h4000; d_sel = 4'hF;
        mid();
        errs = 0;
        for (int k = 1; k <= 4; k++) begin
            step(); mid();
            chk1("t_cyc", bus_cyc, 1'b1);
            errs += int'(bus_err);
            chk1("t_stall", stall, (k == 4) ? 1'b0 : 1'b1);
        end
        chk32("t_drd_c4", d_rdata, 32'h0);
        step(); d_req = 1'b0;
        mid();
        chk1("t_cyc_c5", bus_cyc, 1'b0);
        chk1("t_err_c5", bus_err, 1'b1);
        chk32("t_drd_c5", d_rdata, 32'h0);
        errs += int'(bus_err);
        repeat (3) begin
            step(); mid();
            errs += int'(bus_err);
        end
        chk32("t_err_count", errs, 32'd1);

        // reset mid-wait followed by a late ack
        step(); d_req = 1'b1; d_addr = 32'h5000;
        mid();
        step(); mid();
        chk1("r_cyc_c1", bus_cyc, 1'b1);
        step(); reset = 1'b1; d_req = 1'b0;
        mid(); s_force = 1'b1;
        step(); reset = 1'b0;
        mid(); s_force = 1'b0;
        chk1("r_cyc", bus_cyc, 1'b0);
        chk1("r_stb", bus_stb, 1'b0);
        chk32("r_addr", bus_addr, 32'h0);
        chk32("r_ird", if_rdata, 32'h0);
        chk32("r_drd", d_rdata, 32'h0);
        chk1("r_err", bus_err, 1'b0);
        chk1("r_stall", stall, 1'b0);
        step(); mid();
        chk1("r_cyc_late", bus_cyc, 1'b0);
        chk32("r_drd_late", d_rdata, 32'h0);

        // fetch withdrawn during the wait
        s_wait = 2;
        step(); if_req = 1'b1; if_addr = 32'h600;
        mid(); chk1("w_stall_c0", stall, 1'b1);
        step(); mid(); chk32("w_addr_c1", bus_addr, 32'h600);
        step(); if_req = 1'b0;
        mid();
        chk1("w_cyc_c2", bus_cyc, 1'b1);
        chk1("w_stall_c2", stall, 1'b0);
        step(); mid(); chk32("w_ird_c3", if_rdata, 32'h5A5A0600);
        step(); if_req = 1'b1; if_addr = 32'h200;
        mid();
        chk1("w_cyc_c4", bus_cyc, 1'b0);
        chk1("w_stall_c4", stall, 1'b1);
        s_wait = 0;
        step(); mid();
        chk32("w_addr_c5", bus_addr, 32'h200);
        chk32("w_ird_c5", if_rdata, 32'h5A5A0200);
        chk1("w_stall_c5", stall, 1'b0);
        step(); if_req = 1'b0;
        mid();

        // ack on the same cycle as the timeout
        s_wait = 3;
        step(); if_req = 1'b1; if_addr = 32'h700;
        mid();
        repeat (4) begin
            step(); mid();
        end
        chk32("a_ird", if_rdata, 32'h5A5A0700);
        chk1("a_stall", stall, 1'b0);
        step(); if_req = 1'b0;
        mid();
        chk1("a_err", bus_err, 1'b0);
        chk1("a_cyc", bus_cyc, 1'b0);

        // randomized traffic against the model
        s_mode = 2; s_rand = 1'b1;
        last_stall = stall;
        for (int n = 0; n < 1500; n++) begin
            step();
            reset = ($urandom_range(0, 149) == 0);
            if (!last_stall) begin
                d_req   = ($urandom_range(0, 2) == 0);
                d_we    = $urandom_range(0, 1) != 0;
                d_addr  = $urandom & 32'hFFFF_FFFC;
                d_wdata = $urandom;
                d_sel   = 4'($urandom_range(0, 15));
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            mid();
            last_stall = stall;
        end
        step(); reset = 1'b0; d_req = 1'b0; if_req = 1'b0;
        repeat (8) step();
        mid();
        chk1("end_stall", stall, 1'b0);
        chk1("end_cyc", bus_cyc, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
